// File: rtl/sdram_writer.sv
// Avalon-MM write master: stores one NDWORDS-dword record per request as
// 2*NDWORDS 16-bit beats at baseaddr + index*NDWORDS*4, low halfword first.
module sdram_writer #(
   parameter int unsigned NDWORDS = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [31:0]             baseaddr,
   input  logic [31:0]             index,
   input  logic                    write,
   input  logic [32*NDWORDS-1:0]   data,
   output logic                    oready,
   output logic                    odone,
   output logic                    avm_m0_write,
   output logic [31:0]             avm_m0_address,
   output logic [15:0]             avm_m0_writedata,
   output logic [1:0]              avm_m0_byteenable,
   input  logic                    avm_m0_waitrequest
);

   localparam int unsigned DATA_W    = 32 * NDWORDS;
   localparam int unsigned NBEATS    = 2 * NDWORDS;
   localparam int unsigned BEAT_W    = (NBEATS > 2) ? $clog2(NBEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
   localparam logic [31:0]       REC_BYTES = 32'(NDWORDS * 4);

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   state_t              state;
   logic [BEAT_W-1:0]   beat;
   logic [DATA_W-1:0]   payload;
   logic [31:0]         start_c;

   // Record start address; product and sum wrap modulo 2^32.
   assign start_c = baseaddr + index * REC_BYTES;

   // payload holds the halfwords not yet presented, next one in bits [15:0].
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state             <= IDLE;
         beat              <= '0;
         payload           <= '0;
         oready            <= 1'b1;
         odone             <= 1'b0;
         avm_m0_write      <= 1'b0;
         avm_m0_address    <= '0;
         avm_m0_writedata  <= '0;
         avm_m0_byteenable <= 2'b11;
      end else begin
         odone <= 1'b0;
         case (state)
            IDLE: begin
               if (write) begin
                  state            <= WRITE;
                  oready           <= 1'b0;
                  avm_m0_write     <= 1'b1;
                  avm_m0_address   <= start_c;
                  avm_m0_writedata <= data[15:0];
                  payload          <= data >> 16;
                  beat             <= '0;
               end
            end
            WRITE: begin
               if (!avm_m0_waitrequest) begin
                  if (beat == LAST_BEAT) begin
                     state        <= IDLE;
                     oready       <= 1'b1;
                     odone        <= 1'b1;
                     avm_m0_write <= 1'b0;
                  end else begin
                     beat             <= beat + 1'b1;
                     avm_m0_address   <= avm_m0_address + 32'd2;
                     avm_m0_writedata <= payload[15:0];
                     payload          <= payload >> 16;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_writer.sv
// Scoreboard bench for sdram_writer: the stimulus predicts every halfword
// write and done pulse; a negedge monitor checks what the DUT presents.
module tb_sdram_writer;

   localparam int unsigned N = 2;

   logic             clk = 1'b0;
   logic             i_rstn = 1'b1;
   logic [31:0]      baseaddr = '0;
   logic [31:0]      index = '0;
   logic             write = 1'b0;
   logic [32*N-1:0]  data = '0;
   logic             oready, odone, avm_write;
   logic [31:0]      avm_address;
   logic [15:0]      avm_writedata;
   logic [1:0]       avm_byteenable;
   logic             waitreq = 1'b0;

   sdram_writer #(.NDWORDS(N)) dut (
      .i_clk              (clk),
      .i_rstn             (i_rstn),
      .baseaddr           (baseaddr),
      .index              (index),
      .write              (write),
      .data               (data),
      .oready             (oready),
      .odone              (odone),
      .avm_m0_write       (avm_write),
      .avm_m0_address     (avm_address),
      .avm_m0_writedata   (avm_writedata),
      .avm_m0_byteenable  (avm_byteenable),
      .avm_m0_waitrequest (waitreq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [15:0] hw;
      int          cyc;
   } beat_t;

   beat_t exp_q[$];
   int    done_q[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   bit    wr_rand = 1'b0;
   bit    held_v = 1'b0;
   logic [31:0] held_addr;
   logic [15:0] held_hw;

   always @(posedge clk) cyc <= cyc + 1;

   // Random slave stall, only while enabled.
   always @(posedge clk) begin
      #1;
      if (wr_rand) waitreq = ($urandom_range(0, 2) == 0);
   end

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got event expected none at cycle %0d", nm, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: stability under stall, accepted beats and done pulses.
   always @(negedge clk) begin
      if (!i_rstn) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("hold_write", avm_write, 1);
            check("hold_addr", avm_address, held_addr);
            check("hold_data", avm_writedata, held_hw);
         end
         held_v    = avm_write && waitreq;
         held_addr = avm_address;
         held_hw   = avm_writedata;
         if (avm_write && !waitreq) begin
            check("busy_oready", oready, 0);
            if (exp_q.size() == 0) begin
               flag("extra_beat");
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check("beat_addr", avm_address, e.addr);
               check("beat_data", avm_writedata, e.hw);
               check("beat_be", avm_byteenable, 2'b11);
               if (e.cyc >= 0) check("beat_cycle", cyc, e.cyc);
            end
         end
         if (odone) begin
            check("done_oready", oready, 1);
            if (done_q.size() == 0) begin
               flag("extra_done");
            end else begin
               int dc;
               dc = done_q.pop_front();
               if (dc >= 0) check("done_cycle", cyc, dc);
            end
         end
      end
   end

   // Issue one request when idle; beats stalled sl cycles starting at beat sb.
   task automatic issue(input logic [31:0] b, input logic [31:0] i,
                        input logic [32*N-1:0] d, input int sb, input int sl,
                        input bit timed);
      int guard = 0;
      int p;
      logic [31:0] start;
      while (!oready) begin
         tick();
         guard++;
         if (guard > 300) begin
            flag("issue_timeout");
            return;
         end
      end
      p        = cyc;
      baseaddr = b;
      index    = i;
      data     = d;
      write    = 1'b1;
      start    = b + i * 32'(N * 4);
      for (int k = 0; k < 2 * N; k++) begin
         beat_t e;
         e.addr = start + 32'(2 * k);
         e.hw   = d[16*k +: 16];
         e.cyc  = timed ? p + 1 + k + ((k >= sb) ? sl : 0) : -1;
         exp_q.push_back(e);
      end
      done_q.push_back(timed ? p + 1 + 2 * N + sl : -1);
      tick();
      write    = 1'b0;
      baseaddr = $urandom;
      index    = $urandom;
      data     = {$urandom, $urandom};
   endtask

   task automatic wait_idle();
      int guard = 0;
      while (!(oready && exp_q.size() == 0 && done_q.size() == 0)) begin
         tick();
         guard++;
         if (guard > 400) begin
            flag("idle_timeout");
            exp_q.delete();
            done_q.delete();
            return;
         end
      end
      repeat (3) tick();
   endtask

   localparam logic [63:0] D1 = 64'h3333_4444_1111_2222;

   initial begin
      #3 i_rstn = 1'b0;
      #4;
      check("rst_oready", oready, 1);
      check("rst_odone", odone, 0);
      check("rst_write", avm_write, 0);
      check("rst_addr", avm_address, 0);
      check("rst_data", avm_writedata, 0);
      check("rst_be", avm_byteenable, 2'b11);
      tick();
      i_rstn = 1'b1;
      repeat (2) tick();

      // Basic record, exact latency.
      issue(32'h1000, 32'd3, D1, 99, 0, 1'b1);
      wait_idle();

      // Three-cycle stall on beat 1.
      issue(32'h1000, 32'd3, D1, 1, 3, 1'b1);
      tick();
      waitreq = 1'b1;
      repeat (3) tick();
      waitreq = 1'b0;
      wait_idle();

      // Requests while busy are dropped.
      issue(32'h1000, 32'd3, D1, 99, 0, 1'b1);
      tick();
      index = 32'd7; write = 1'b1;
      tick();
      write = 1'b0;
      tick();
      index = 32'd7; write = 1'b1;
      tick();
      write = 1'b0;
      wait_idle();

      // Back-to-back: second request lands in the odone cycle.
      issue(32'h1000, 32'd3, D1, 99, 0, 1'b1);
      issue(32'h1000, 32'd4, 64'hAAAA_BBBB_CCCC_DDDD, 99, 0, 1'b1);
      wait_idle();

      // Address wrap-around.
      issue(32'hFFFF_FFF8, 32'd1, 64'h0123_4567_89AB_CDEF, 99, 0, 1'b1);
      wait_idle();

      // Reset during beat 2 abandons the record.
      issue(32'h1000, 32'd3, D1, 99, 0, 1'b1);
      repeat (2) tick();
      #2 i_rstn = 1'b0;
      #1;
      check("rst_mid_write", avm_write, 0);
      check("rst_mid_oready", oready, 1);
      check("rst_mid_odone", odone, 0);
      exp_q.delete();
      done_q.delete();
      repeat (2) tick();
      i_rstn = 1'b1;
      tick();
      check("post_rst_oready", oready, 1);
      issue(32'h2000, 32'd5, 64'hDEAD_BEEF_CAFE_F00D, 99, 0, 1'b1);
      wait_idle();

      // Randomized records under random stalls with spurious requests.
      wr_rand = 1'b1;
      for (int n = 0; n < 30; n++) begin
         issue($urandom, $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 64),
               {$urandom, $urandom}, 99, 0, 1'b0);
         if ($urandom_range(0, 1) == 1 && !oready) begin
            write = 1'b1;
            tick();
            write = 1'b0;
         end
      end
      wr_rand = 1'b0;
      #1 waitreq = 1'b0;
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
